universal_register: RTL and testbench

- Parametrised successor of the team's 8-bit set/reset register.
- Generalised to WIDTH bits, with a 3-bit mode select covering hold, load, shift, rotate and up/down count, plus carry and zero flags.
- Used as the general storage/shift/count element in the datapath and as a drop-in for the fixed 8-bit register when WIDTH=8, en=s and clr=r.

---
 rtl/ureg_pkg.sv | 15 +
 rtl/ureg_next.sv | 69 ++++++
 rtl/universal_register.sv | 63 ++++++
 tb/tb_universal_register.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ureg_pkg.sv
// rtl/ureg_pkg.sv - shared mode encodings and limits for universal_register
package ureg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam int WIDTH_MIN = 2;

endpackage

// File: rtl/ureg_next.sv
// rtl/ureg_next.sv - combinational next-state and carry function of universal_register
module ureg_next
  import ureg_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             carry,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             carry_next
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  always_comb begin
    q_next     = q;
    carry_next = 1'b0;
    case (mode)
      MODE_HOLD: begin
        q_next     = q;
        carry_next = 1'b0;
      end
      MODE_LOAD: q_next = d;
      MODE_SHL: begin
        q_next     = {q[WIDTH-2:0], ser_in};
        carry_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next     = {ser_in, q[WIDTH-1:1]};
        carry_next = q[0];
      end
      MODE_ROL: begin
        q_next     = {q[WIDTH-2:0], q[WIDTH-1]};
        carry_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next     = {q[0], q[WIDTH-1:1]};
        carry_next = q[0];
      end
      MODE_INC: begin
        // carry flags the boundary whether the count wraps or clamps
        if (q == ALL_ONES) begin
          q_next     = SATURATE ? ALL_ONES : '0;
          carry_next = 1'b1;
        end else begin
          q_next = q + ONE;
        end
      end
      MODE_DEC: begin
        if (q == '0) begin
          q_next     = SATURATE ? '0 : ALL_ONES;
          carry_next = 1'b1;
        end else begin
          q_next = q - ONE;
        end
      end
      default: begin
        q_next     = q;
        carry_next = carry;
      end
    endcase
  end

endmodule

// File: rtl/universal_register.sv
// rtl/universal_register.sv - WIDTH-bit load/shift/rotate/count register with carry and zero flags
module universal_register
  import ureg_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  generate
    if (WIDTH < WIDTH_MIN) begin : g_width_check
      $error("universal_register: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] q_next;
  logic             carry_next;

  ureg_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_next (
    .mode       (mode),
    .q          (q),
    .carry      (carry),
    .d          (d),
    .ser_in     (ser_in),
    .q_next     (q_next),
    .carry_next (carry_next)
  );

  // clear wins over enable, so clr with en=1/LOAD still zeroes the register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= RST_Q;
      carry <= 1'b0;
    end else if (clr) begin
      q     <= '0;
      carry <= 1'b0;
    end else if (en) begin
      q     <= q_next;
      carry <= carry_next;
    end
  end

  assign zero = (q == '0);

  mode_known_a: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown(mode));

endmodule

// File: tb/tb_universal_register.sv
// tb/tb_universal_register.sv - directed self-checking bench for universal_register
module tb_universal_register;
  import ureg_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic [2:0]  mode;
  logic [15:0] d;
  logic        ser_in;

  logic [7:0]  q8;
  logic        c8, z8;
  logic [3:0]  q4;
  logic        c4, z4;
  logic [15:0] q16;
  logic        c16, z16;

  int n_checks = 0;
  int n_fail   = 0;

  universal_register #(.WIDTH(8), .RESET_VAL(32'hA5), .SATURATE(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .d(d[7:0]),
    .ser_in(ser_in), .q(q8), .carry(c8), .zero(z8)
  );

  universal_register #(.WIDTH(4), .RESET_VAL(32'h0), .SATURATE(1'b1)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .d(d[3:0]),
    .ser_in(ser_in), .q(q4), .carry(c4), .zero(z4)
  );

  universal_register #(.WIDTH(16), .RESET_VAL(32'h1234), .SATURATE(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .mode(mode), .d(d),
    .ser_in(ser_in), .q(q16), .carry(c16), .zero(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [15:0] dv, input logic si);
    en = 1'b1; mode = m; d = dv; ser_in = si;
    tick();
  endtask

  initial begin
    rst_n = 1'b1; clr = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; ser_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_q8", 32'(q8), 32'hA5);
    check("rst_c8", 32'(c8), 32'h0);
    check("rst_z8", 32'(z8), 32'h0);
    check("rst_q4", 32'(q4), 32'h0);
    check("rst_z4", 32'(z4), 32'h1);
    check("rst_q16", 32'(q16), 32'h1234);
    tick();
    rst_n = 1'b1;

    // async reset between edges with carry set
    op(MODE_LOAD, 16'h00F0, 1'b0);
    op(MODE_SHL, 16'h0000, 1'b0);
    check("pre_rst_q8", 32'(q8), 32'hE0);
    check("pre_rst_c8", 32'(c8), 32'h1);
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q8", 32'(q8), 32'hA5);
    check("async_rst_c8", 32'(c8), 32'h0);
    #1 rst_n = 1'b1;

    // clr beats en=1/LOAD
    op(MODE_LOAD, 16'd123, 1'b0);
    check("load123", 32'(q8), 32'd123);
    clr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      op(MODE_LOAD, 16'(i), 1'b0);
      check("clr_pri", 32'(q8), 32'h0);
    end
    clr = 1'b0;
    op(MODE_LOAD, 16'd123, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d = 16'(i);
      tick();
      check("en0_hold", 32'(q8), 32'd123);
    end
    for (int i = 0; i < 256; i++) begin
      op(MODE_LOAD, 16'(i), 1'b0);
      check("load_all", 32'(q8), 32'(i));
    end

    // shifts and rotates
    op(MODE_LOAD, 16'h0081, 1'b0);
    op(MODE_SHL, 16'h0000, 1'b1);
    check("shl_q", 32'(q8), 32'h03);
    check("shl_c", 32'(c8), 32'h1);
    op(MODE_SHR, 16'h0000, 1'b0);
    check("shr_q", 32'(q8), 32'h01);
    check("shr_c", 32'(c8), 32'h1);
    op(MODE_ROL, 16'h0000, 1'b0);
    check("rol1_q", 32'(q8), 32'h02);
    check("rol1_c", 32'(c8), 32'h0);
    for (int i = 0; i < 7; i++) op(MODE_ROL, 16'h0000, 1'b1);
    check("rol8_q", 32'(q8), 32'h01);
    check("rol8_c", 32'(c8), 32'h1);
    op(MODE_ROR, 16'h0000, 1'b0);
    check("ror_q", 32'(q8), 32'h80);
    check("ror_c", 32'(c8), 32'h1);

    // wrap counting, SATURATE=0
    op(MODE_LOAD, 16'h00FE, 1'b0);
    op(MODE_INC, 16'h0000, 1'b0);
    check("inc1_q", 32'(q8), 32'hFF);
    check("inc1_c", 32'(c8), 32'h0);
    op(MODE_INC, 16'h0000, 1'b0);
    check("inc_wrap_q", 32'(q8), 32'h00);
    check("inc_wrap_c", 32'(c8), 32'h1);
    check("inc_wrap_z", 32'(z8), 32'h1);
    en = 1'b0;
    tick();
    check("carry_hold", 32'(c8), 32'h1);
    op(MODE_DEC, 16'h0000, 1'b0);
    check("dec_wrap_q", 32'(q8), 32'hFF);
    check("dec_wrap_c", 32'(c8), 32'h1);
    op(MODE_DEC, 16'h0000, 1'b0);
    check("dec_q", 32'(q8), 32'hFE);
    check("dec_c", 32'(c8), 32'h0);
    op(MODE_HOLD, 16'h0000, 1'b0);
    check("hold_q", 32'(q8), 32'hFE);

    // saturating counter, WIDTH=4
    op(MODE_LOAD, 16'h000F, 1'b0);
    op(MODE_INC, 16'h0000, 1'b0);
    check("sat_inc_q", 32'(q4), 32'hF);
    check("sat_inc_c", 32'(c4), 32'h1);
    op(MODE_LOAD, 16'h0000, 1'b0);
    op(MODE_DEC, 16'h0000, 1'b0);
    check("sat_dec_q", 32'(q4), 32'h0);
    check("sat_dec_c", 32'(c4), 32'h1);
    check("sat_dec_z", 32'(z4), 32'h1);
    op(MODE_INC, 16'h0000, 1'b0);
    check("sat_inc_from0", 32'(q4), 32'h1);
    check("sat_inc_from0_c", 32'(c4), 32'h0);

    // mid-rotation reset, WIDTH=16
    op(MODE_LOAD, 16'h8001, 1'b0);
    op(MODE_ROL, 16'h0000, 1'b0);
    check("rol16_1_q", 32'(q16), 32'h0003);
    check("rol16_1_c", 32'(c16), 32'h1);
    op(MODE_ROL, 16'h0000, 1'b0);
    op(MODE_ROL, 16'h0000, 1'b0);
    check("rol16_3_q", 32'(q16), 32'h000C);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q16", 32'(q16), 32'h1234);
    check("mid_rst_c16", 32'(c16), 32'h0);
    #1 rst_n = 1'b1;
    op(MODE_HOLD, 16'hFFFF, 1'b1);
    check("post_rst_hold_q16", 32'(q16), 32'h1234);
    check("post_rst_hold_q8", 32'(q8), 32'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
